// File: rtl/psr_update_ctrl_if.sv
// Bus between the ALU/branch/interrupt logic and the status-register controller.
// The master drives requests and the slave returns flags, status and the branch decision.
interface psr_update_ctrl_if #(
    parameter int Bits  = 12,
    parameter int Depth = 4
);
    localparam int DEPTH_W = $clog2(Depth + 1);

    logic [Bits:0]        iData;
    logic                 iValid;
    logic [4:0]           iMask;
    logic                 oReady;
    logic                 iSave;
    logic                 iRestore;
    logic [2:0]           iCond;
    logic                 oCondTrue;
    logic [4:0]           oPSR;
    logic [DEPTH_W-1:0]   oDepth;
    logic                 oError;

    modport master (
        output iData, iValid, iMask, iSave, iRestore, iCond,
        input  oReady, oCondTrue, oPSR, oDepth, oError
    );

    modport slave (
        input  iData, iValid, iMask, iSave, iRestore, iCond,
        output oReady, oCondTrue, oPSR, oDepth, oError
    );
endinterface

// File: rtl/psr_update_ctrl.sv
// Processor status register owner: stages ALU results, commits masked flags one cycle
// after acceptance, keeps a save/restore shadow stack, and evaluates branch conditions.
module psr_update_ctrl #(
    parameter int Bits  = 12,
    parameter int Depth = 4
) (
    input  logic                 iClk,
    input  logic                 iReset,
    psr_update_ctrl_if.slave     bus
);
    localparam int DEPTH_W = $clog2(Depth + 1);
    localparam int IDX_W   = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [0:0] {IDLE, COMMIT} state_e;

    state_e               state_q, state_d;
    logic [Bits:0]        stage_data_q, stage_data_d;
    logic [4:0]           stage_mask_q, stage_mask_d;
    logic [4:0]           psr_q, psr_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q, err_d;
    logic [4:0]           stack_q [Depth];
    logic                 push_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [4:0]           new_flags;

    // Flag order is {N, Z, P, E, C}; zero ignores the carry, parity covers it.
    function automatic logic [4:0] calc_flags(input logic [Bits:0] d);
        logic [4:0] f;
        f[0] = d[Bits];
        f[1] = ~d[0];
        f[2] = ^d;
        f[3] = ~|d[Bits-1:0];
        f[4] = d[Bits-1];
        return f;
    endfunction

    function automatic logic eval_cond(input logic [2:0] sel, input logic [4:0] psr);
        logic r;
        unique case (sel)
            3'd0: r = 1'b1;
            3'd1: r = psr[3];
            3'd2: r = ~psr[3];
            3'd3: r = psr[0];
            3'd4: r = ~psr[0];
            3'd5: r = psr[4];
            3'd6: r = ~psr[4];
            3'd7: r = psr[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign wr_idx    = IDX_W'(depth_q);
    assign rd_idx    = IDX_W'(depth_q - DEPTH_W'(1));
    assign new_flags = calc_flags(stage_data_q);

    always_comb begin
        state_d      = state_q;
        stage_data_d = stage_data_q;
        stage_mask_d = stage_mask_q;
        psr_d        = psr_q;
        depth_d      = depth_q;
        err_d        = err_q;
        push_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only the highest-priority request is serviced; the rest are dropped.
                if (bus.iRestore) begin
                    if (depth_q != '0) begin
                        psr_d   = stack_q[rd_idx];
                        depth_d = depth_q - DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.iSave) begin
                    if (depth_q < DEPTH_W'(Depth)) begin
                        push_en = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.iValid) begin
                    stage_data_d = bus.iData;
                    stage_mask_d = bus.iMask;
                    state_d      = COMMIT;
                end
            end
            COMMIT: begin
                psr_d   = (new_flags & stage_mask_q) | (psr_q & ~stage_mask_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q      <= IDLE;
            stage_data_q <= '0;
            stage_mask_q <= '0;
            psr_q        <= '0;
            depth_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_data_q <= stage_data_d;
            stage_mask_q <= stage_mask_d;
            psr_q        <= psr_d;
            depth_q      <= depth_d;
            err_q        <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge iClk) begin
        if (push_en && !iReset) begin
            stack_q[wr_idx] <= psr_q;
        end
    end

    assign bus.oReady    = (state_q == IDLE);
    assign bus.oPSR      = psr_q;
    assign bus.oDepth    = depth_q;
    assign bus.oError    = err_q;
    assign bus.oCondTrue = eval_cond(bus.iCond, psr_q);
endmodule

// File: tb/tb_psr_update_ctrl.sv
// Directed bench for psr_update_ctrl with a per-cycle behavioural scoreboard.
module tb_psr_update_ctrl;
    logic iClk = 1'b0;
    logic iReset = 1'b1;

    psr_update_ctrl_if #(.Bits(12), .Depth(4)) bus ();

    psr_update_ctrl #(.Bits(12), .Depth(4)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: flags, shadow stack as a queue, and one pending staged update.
    logic [4:0]  m_psr = '0;
    bit          m_err = 1'b0;
    logic [4:0]  m_stack [$];
    bit          m_pend = 1'b0;
    logic [12:0] m_pdata = '0;
    logic [4:0]  m_pmask = '0;

    function automatic logic [4:0] model_flags(input logic [12:0] d);
        int unsigned v;
        logic c, e, p, z, n;
        v = int'(d);
        c = ((v / 4096) % 2) == 1;
        e = (v % 2) == 0;
        p = ($countones(d) % 2) == 1;
        z = (v % 4096) == 0;
        n = ((v / 2048) % 2) == 1;
        return {n, z, p, e, c};
    endfunction

    function automatic logic model_cond(input logic [2:0] sel, input logic [4:0] f);
        logic c, p, z, n;
        c = f[0]; p = f[2]; z = f[3]; n = f[4];
        case (sel)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return c;
            3'd4: return !c;
            3'd5: return n;
            3'd6: return !n;
            default: return p;
        endcase
    endfunction

    always @(posedge iClk) begin
        if (iReset) begin
            m_psr = '0; m_err = 1'b0; m_pend = 1'b0; m_stack.delete();
        end else if (m_pend) begin
            for (int b = 0; b < 5; b++)
                if (m_pmask[b]) m_psr[b] = model_flags(m_pdata)[b];
            m_pend = 1'b0;
        end else if (bus.iRestore) begin
            if (m_stack.size() > 0) m_psr = m_stack.pop_back();
            else m_err = 1'b1;
        end else if (bus.iSave) begin
            if (m_stack.size() < 4) m_stack.push_back(m_psr);
            else m_err = 1'b1;
        end else if (bus.iValid) begin
            m_pdata = bus.iData; m_pmask = bus.iMask; m_pend = 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iClk) begin
        if (chk_en) begin
            check("sb_ready", int'(bus.oReady), int'(!m_pend));
            check("sb_psr",   int'(bus.oPSR),   int'(m_psr));
            check("sb_depth", int'(bus.oDepth), m_stack.size());
            check("sb_error", int'(bus.oError), int'(m_err));
            check("sb_cond",  int'(bus.oCondTrue), int'(model_cond(bus.iCond, m_psr)));
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iValid = 1'b0; bus.iSave = 1'b0; bus.iRestore = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
    endtask

    task automatic alu(input logic [12:0] d, input logic [4:0] m);
        bus.iData = d; bus.iMask = m; bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        tick();
    endtask

    logic [12:0] pat_data [8] = '{13'h0000, 13'h1FFF, 13'h0800, 13'h1001,
                                  13'h0AAA, 13'h0555, 13'h1800, 13'h0002};
    logic [4:0]  pat_mask [8] = '{5'h1F, 5'h15, 5'h0A, 5'h1F, 5'h03, 5'h1C, 5'h1F, 5'h08};

    initial begin
        bus.iData = '0; bus.iMask = '0; bus.iCond = 3'd0;
        idle_inputs();
        do_reset();
        chk_en = 1'b1;

        check("rst_ready", int'(bus.oReady), 1);
        check("rst_psr",   int'(bus.oPSR),   0);
        check("rst_depth", int'(bus.oDepth), 0);
        check("rst_error", int'(bus.oError), 0);

        // Accept, one busy cycle, then commit.
        bus.iData = 13'h1000; bus.iMask = 5'h1F; bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        check("busy_ready", int'(bus.oReady), 0);
        check("busy_psr",   int'(bus.oPSR),   0);
        tick();
        check("commit_ready", int'(bus.oReady), 1);
        check("commit_psr",   int'(bus.oPSR),   5'h0F);

        alu(13'h0801, 5'h01);
        check("mask_c_only", int'(bus.oPSR), 5'h0E);
        alu(13'h0801, 5'h1F);
        check("mask_all", int'(bus.oPSR), 5'h10);

        alu(13'h1000, 5'h1F);
        bus.iCond = 3'd1; #1; check("cond_z",   int'(bus.oCondTrue), 1);
        bus.iCond = 3'd4; #1; check("cond_nc",  int'(bus.oCondTrue), 0);
        bus.iCond = 3'd7; #1; check("cond_p",   int'(bus.oCondTrue), 1);
        bus.iCond = 3'd0; #1; check("cond_all", int'(bus.oCondTrue), 1);

        // Fill the stack, overflow once, then restore the newest entry.
        bus.iSave = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("save4_depth", int'(bus.oDepth), 4);
        check("save4_error", int'(bus.oError), 0);
        tick();
        bus.iSave = 1'b0;
        check("save5_depth", int'(bus.oDepth), 4);
        check("save5_error", int'(bus.oError), 1);
        alu(13'h0801, 5'h1F);
        check("pre_restore_psr", int'(bus.oPSR), 5'h10);
        bus.iRestore = 1'b1;
        tick();
        bus.iRestore = 1'b0;
        check("restore_psr",   int'(bus.oPSR),   5'h0F);
        check("restore_depth", int'(bus.oDepth), 3);

        // Underflow after a fresh reset.
        do_reset();
        alu(13'h0801, 5'h1F);
        bus.iRestore = 1'b1;
        tick();
        bus.iRestore = 1'b0;
        check("underflow_error", int'(bus.oError), 1);
        check("underflow_psr",   int'(bus.oPSR),   5'h10);

        // Simultaneous requests: only the restore happens.
        bus.iSave = 1'b1; tick(); bus.iSave = 1'b0;
        alu(13'h1000, 5'h1F);
        bus.iData = 13'h0801; bus.iMask = 5'h01;
        bus.iSave = 1'b1; bus.iRestore = 1'b1; bus.iValid = 1'b1;
        tick();
        idle_inputs();
        check("prio_psr",   int'(bus.oPSR),   5'h10);
        check("prio_depth", int'(bus.oDepth), 0);
        check("prio_ready", int'(bus.oReady), 1);
        tick();
        check("prio_hold_psr", int'(bus.oPSR), 5'h10);

        // Reset during the commit cycle discards the staged update.
        bus.iData = 13'h1000; bus.iMask = 5'h1F; bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        check("rstc_psr",   int'(bus.oPSR),   0);
        check("rstc_depth", int'(bus.oDepth), 0);
        check("rstc_ready", int'(bus.oReady), 1);
        tick();
        check("rstc_after_psr", int'(bus.oPSR), 0);

        // Pattern sweep checked by the scoreboard, with requests held through COMMIT.
        for (int i = 0; i < 8; i++) begin
            bus.iCond = 3'(i);
            bus.iData = pat_data[i]; bus.iMask = pat_mask[i]; bus.iValid = 1'b1;
            tick();
            bus.iSave = (i % 3 == 0);
            tick();
            bus.iValid = 1'b0;
            tick();
            bus.iSave = 1'b0;
            bus.iRestore = (i % 4 == 3);
            tick();
            bus.iRestore = 1'b0;
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
